// File: rtl/instr_encoder.sv
// instr_encoder: turns ALU operation requests into RV32I R-type / I-type
// instruction words, buffers them in a small FIFO and streams them to an
// instruction memory at consecutive word addresses.
//
// Optional feature: define INSTR_COUNT_EN to add a 16-bit saturating
// word_count output that counts completed memory writes.
//
// Handshakes (both sides): a transfer happens on the rising edge where the
// producer's valid and the consumer's ready are both high. Once asserted,
// the request fields are sampled only at that edge. in_ready depends only
// on registered FIFO state, never combinationally on mem_ready.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic        imm_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  input  logic        restart,
  input  logic [31:0] base_addr,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        err
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0] word_count
`endif
);

  // Pointer index width; pointers carry one extra wrap bit so that
  // full and empty can be told apart when the indices match.
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [6:0]  OPC_R    = 7'b0110011;
  localparam logic [6:0]  OPC_I    = 7'b0010011;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;
  localparam logic [6:0]  F7_BASE  = 7'b0000000;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [31:0] ADDR_INC = 32'd4;

  // ALU op codes as presented on the op input
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]  addr_q,   addr_d;
  logic         err_q,    err_d;
  logic [31:0]  fifo_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------
  // Encoder signals
  // ---------------------------------------------------------------------
  logic [2:0]   f3;
  logic [6:0]   upper7;
  logic         op_known;
  logic         illegal;
  logic [31:0]  enc_word;

  // Handshake / FIFO status
  logic         fifo_empty;
  logic         fifo_full;
  logic         accept;
  logic         push;
  logic         pop;

  // Decode op into funct3 and flag requests that have no encoding
  always_comb begin
    f3       = 3'b000;
    op_known = 1'b1;
    unique case (op)
      OP_ADD, OP_SUB: f3 = 3'b000;
      OP_SLL:         f3 = 3'b001;
      OP_SLT:         f3 = 3'b010;
      OP_SLTU:        f3 = 3'b011;
      OP_XOR:         f3 = 3'b100;
      OP_SRL, OP_SRA: f3 = 3'b101;
      OP_OR:          f3 = 3'b110;
      OP_AND:         f3 = 3'b111;
      default:        op_known = 1'b0;
    endcase
    // There is no "subi": an immediate subtract is rejected.
    illegal = !op_known || (imm_sel && (op == OP_SUB));
  end

  // Assemble the instruction word for the current request
  always_comb begin
    upper7   = F7_BASE;
    enc_word = '0;
    if (imm_sel) begin
      // Shifts keep only imm[4:0] as shamt; the top seven bits carry the
      // shift-kind selector instead of immediate bits.
      if ((op == OP_SLL) || (op == OP_SRL)) begin
        upper7 = F7_BASE;
      end else if (op == OP_SRA) begin
        upper7 = F7_ALT;
      end else begin
        upper7 = imm[11:5];
      end
      enc_word = {upper7, imm[4:0], rs1, f3, rd, OPC_I};
    end else begin
      if ((op == OP_SUB) || (op == OP_SRA)) begin
        upper7 = F7_ALT;
      end else begin
        upper7 = F7_BASE;
      end
      enc_word = {upper7, rs2, rs1, f3, rd, OPC_R};
    end
  end

  // FIFO status and handshake qualification
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    in_ready   = !fifo_full;
    mem_we     = !fifo_empty;
    accept     = in_valid && in_ready;
    push       = accept && !illegal;
    pop        = mem_we && mem_ready;
  end

  // Head word, forced to zero while nothing is buffered so stale data
  // never appears on the memory bus.
  always_comb begin
    mem_wdata = '0;
    if (!fifo_empty) begin
      mem_wdata = fifo_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign mem_addr = addr_q;
  assign err      = err_q;

  // Next-state: restart wins over any same-cycle push/pop and error
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    err_d    = 1'b0;
    if (restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      addr_d   = base_addr;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        addr_d   = addr_q + ADDR_INC;
      end
      err_d = accept && illegal;
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents are only observable through the pointers,
  // so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push && !restart) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= enc_word;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] count_q, count_d;

  // Next completed-write count, saturating at all ones
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (pop && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Completed-write counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign word_count = count_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encoded words, plus hand-written
// sequences for back-pressure, restart and asynchronous reset.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  op;
    logic        imm_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        imm_sel;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm;
  logic        restart;
  logic [31:0] base_addr;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        err;
`ifdef INSTR_COUNT_EN
  logic [15:0] word_count;
`endif

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .imm_sel   (imm_sel),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .restart   (restart),
    .base_addr (base_addr),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .err       (err)
`ifdef INSTR_COUNT_EN
    ,
    .word_count(word_count)
`endif
  );

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        exp_err;
  int          exp_wc;
  logic        cur_legal;
  logic [31:0] cur_word;
  int          checks;
  int          errors;
  int          err_seen;
  vec_t        vecs[16];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic s, input logic [4:0] d,
                              input logic [4:0] a, input logic [4:0] b, input logic [11:0] i,
                              input logic lg, input logic [31:0] w);
    vec_t v;
    v.op = o; v.imm_sel = s; v.rd = d; v.rs1 = a; v.rs2 = b; v.imm = i;
    v.legal = lg; v.word = w;
    return v;
  endfunction

  // One clock: compare outputs against the model at the falling edge, update
  // the model with what the coming rising edge will do, return at edge + 1.
  task automatic cycle();
    logic model_ready;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      exp_addr = '0;
      exp_err  = 1'b0;
      exp_wc   = 0;
    end else begin
      check1("in_ready", in_ready, exp_q.size() < DEPTH);
      check1("mem_we", mem_we, exp_q.size() != 0);
      check32("mem_addr", mem_addr, exp_addr);
      check1("err", err, exp_err);
      if (exp_q.size() != 0) check32("mem_wdata", mem_wdata, exp_q[0]);
`ifdef INSTR_COUNT_EN
      check32("word_count", {16'd0, word_count}, exp_wc);
`endif
      if (err) err_seen++;
      if (restart) begin
        exp_q.delete();
        exp_addr = base_addr;
        exp_err  = 1'b0;
        exp_wc   = 0;
      end else begin
        model_ready = exp_q.size() < DEPTH;
        if (mem_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          exp_addr = exp_addr + 32'd4;
          if (exp_wc < 65535) exp_wc++;
        end
        exp_err = in_valid && model_ready && !cur_legal;
        if (in_valid && model_ready && cur_legal) exp_q.push_back(cur_word);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic drive(input vec_t v);
    op = v.op; imm_sel = v.imm_sel; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    cur_legal = v.legal; cur_word = v.word;
  endtask

  // driver: hold the request until the handshake edge (bounded)
  task automatic send(input vec_t v);
    logic acc;
    acc = 1'b0;
    drive(v);
    in_valid = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      acc = in_ready;
      cycle();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never high for op %0d", v.op);
    end
  endtask

  task automatic do_restart(input logic [31:0] base);
    base_addr = base;
    restart   = 1'b1;
    cycle();
    restart   = 1'b0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; restart = 1'b0; mem_ready = 1'b0; base_addr = '0;
    op = '0; imm_sel = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    cur_legal = 1'b1; cur_word = '0;
    exp_addr = '0; exp_err = 1'b0; exp_wc = 0;
    checks = 0; errors = 0; err_seen = 0;

    //            op     sel   rd     rs1    rs2    imm       legal word
    vecs[0]  = mk(4'd0,  1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 1'b1, 32'h003100B3);
    vecs[1]  = mk(4'd1,  1'b0, 5'd5,  5'd6,  5'd7,  12'h000, 1'b1, 32'h407302B3);
    vecs[2]  = mk(4'd7,  1'b1, 5'd1,  5'd1,  5'd0,  12'h003, 1'b1, 32'h4030D093);
    vecs[3]  = mk(4'd2,  1'b0, 5'd10, 5'd11, 5'd12, 12'hABC, 1'b1, 32'h00C59533);
    vecs[4]  = mk(4'd3,  1'b1, 5'd3,  5'd4,  5'd0,  12'hFFF, 1'b1, 32'hFFF22193);
    vecs[5]  = mk(4'd4,  1'b0, 5'd31, 5'd30, 5'd29, 12'h000, 1'b1, 32'h01DF3FB3);
    vecs[6]  = mk(4'd5,  1'b1, 5'd2,  5'd0,  5'd31, 12'h555, 1'b1, 32'h55504113);
    vecs[7]  = mk(4'd6,  1'b1, 5'd7,  5'd8,  5'd0,  12'hFE5, 1'b1, 32'h00545393);
    vecs[8]  = mk(4'd7,  1'b0, 5'd9,  5'd10, 5'd11, 12'h000, 1'b1, 32'h40B554B3);
    vecs[9]  = mk(4'd8,  1'b0, 5'd4,  5'd5,  5'd6,  12'h123, 1'b1, 32'h0062E233);
    vecs[10] = mk(4'd9,  1'b1, 5'd1,  5'd1,  5'd0,  12'h0FF, 1'b1, 32'h0FF0F093);
    vecs[11] = mk(4'd2,  1'b1, 5'd1,  5'd2,  5'd0,  12'hFFF, 1'b1, 32'h01F11093);
    vecs[12] = mk(4'd7,  1'b1, 5'd0,  5'd0,  5'd0,  12'h01F, 1'b1, 32'h41F05013);
    vecs[13] = mk(4'd1,  1'b1, 5'd3,  5'd3,  5'd0,  12'h001, 1'b0, 32'h0);
    vecs[14] = mk(4'd12, 1'b0, 5'd3,  5'd3,  5'd3,  12'h000, 1'b0, 32'h0);
    vecs[15] = mk(4'd10, 1'b1, 5'd3,  5'd3,  5'd0,  12'h000, 1'b0, 32'h0);

    // reset values
    idle(2);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_mem_we", mem_we, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    check1("rst_err", err, 1'b0);
    rst = 1'b0;
    cycle();

    // table: one request at a time, memory always ready
    do_restart(32'h100);
    check32("restart_addr", mem_addr, 32'h100);
    mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(vecs[i]);
      if (vecs[i].legal) begin
        check1($sformatf("v%0d_we", i), mem_we, 1'b1);
        check32($sformatf("v%0d_word", i), mem_wdata, vecs[i].word);
        check1($sformatf("v%0d_err", i), err, 1'b0);
      end else begin
        check1($sformatf("v%0d_we", i), mem_we, 1'b0);
        check1($sformatf("v%0d_err", i), err, 1'b1);
      end
      idle(2);
    end
    check32("err_pulses", err_seen, 32'd3);
    check32("table_addr", mem_addr, 32'h100 + 32'd4 * 32'd13);

    // back-pressure: fill the FIFO, hold a fifth request, then release
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vecs[i + 3]);
    check1("full_in_ready", in_ready, 1'b0);
    drive(vecs[8]);
    in_valid = 1'b1;
    idle(2);
    check1("full_hold", in_ready, 1'b0);
    check32("full_head", mem_wdata, vecs[3].word);
    mem_ready = 1'b1;
    send(vecs[8]);
    idle(6);
    check1("bp_drained", mem_we, 1'b0);

    // restart with buffered words and a concurrent legal request
    mem_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    drive(vecs[5]);
    in_valid = 1'b1;
    do_restart(32'hFFFF_FFF8);
    in_valid = 1'b0;
    check1("rs_flush_we", mem_we, 1'b0);
    check32("rs_addr", mem_addr, 32'hFFFF_FFF8);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(vecs[i + 9]);
    idle(3);
    check32("wrap_addr", mem_addr, 32'h0000_0004);

    // restart with a concurrent illegal request: no error pulse
    drive(vecs[14]);
    in_valid = 1'b1;
    do_restart(32'h200);
    in_valid = 1'b0;
    check1("rs_no_err", err, 1'b0);

    // three completed writes, then restart clears the count
    for (int i = 0; i < 3; i++) send(vecs[i]);
    idle(3);
    check32("three_addr", mem_addr, 32'h20C);
`ifdef INSTR_COUNT_EN
    check32("wc_three", {16'd0, word_count}, 32'd3);
`endif
    do_restart(32'h300);
`ifdef INSTR_COUNT_EN
    check32("wc_cleared", {16'd0, word_count}, 32'd0);
`endif

    // asynchronous reset with three words stuck behind a busy memory
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i + 4]);
    idle(1);
    check1("pre_rst_we", mem_we, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check1("arst_we", mem_we, 1'b0);
    check32("arst_addr", mem_addr, 32'h0);
    check32("arst_wdata", mem_wdata, 32'h0);
    check1("arst_err", err, 1'b0);
    check1("arst_in_ready", in_ready, 1'b1);
    idle(2);
    rst = 1'b0;
    mem_ready = 1'b1;
    idle(4);
    check1("post_rst_we", mem_we, 1'b0);
    check32("post_rst_addr", mem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of encoded words buffered (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  request accepted on the edge where in_valid and in_ready are both high.
REQ-006 op  input  4  ALU op: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
REQ-007 imm_sel  input  1  1 = I-type (opcode 0010011); 0 = R-type (opcode 0110011).
REQ-008 rd, rs1, rs2  input  5 each  register indices; rs2 is ignored when imm_sel=1.
REQ-009 imm  input  12  immediate; only [4:0] is used for shifts.
REQ-010 restart  input  1  synchronous pulse: flush FIFO and load address from base_addr.
REQ-011 base_addr  input  32  start address sampled on restart.
REQ-012 mem_we  output  1  instruction-memory write request.
REQ-013 mem_ready  input  1  memory accepts the write on the edge where mem_we and mem_ready are both high.
REQ-014 mem_addr  output  32  write address.
REQ-015 mem_wdata  output  32  encoded instruction word.
REQ-016 err  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-017 f3 mapping: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111.
REQ-018 R-type word: {f7, rs2, rs1, f3, rd, 0110011}; f7 = 0100000 for sub and sra, otherwise 0000000.
REQ-019 I-type word: {imm[11:0], rs1, f3, rd, 0010011}, with shift overrides below.
REQ-020 I-type sll/srl: bits[31:25] forced to 0000000; I-type sra: bits[31:25] forced to 0100000; bits[24:20] = imm[4:0].
REQ-021 Illegal request: op > 9, or op = 1 with imm_sel = 1.
  - Still consumed by the handshake.
  - Not written to the FIFO.
  - err high for exactly the cycle after acceptance.
REQ-022 in_ready = FIFO not full, computed from registered state only (no combinational path from mem_ready).
REQ-023 Latency: a legal request accepted at edge N presents its word on mem_we/mem_wdata no earlier than the cycle after edge N.
REQ-024 FIFO output: mem_we = FIFO not empty; mem_wdata = head entry.
  - Pop when mem_we and mem_ready are both high.
  - Words leave in acceptance order.
REQ-025 mem_addr advances by 4 on each pop and wraps modulo 2^32.
REQ-026 Simultaneous push and pop when the FIFO is neither full nor empty: occupancy unchanged.
  - Full: push impossible; pop proceeds.
  - Empty: only push.
REQ-027 restart has priority over push and pop in the same cycle:
  - FIFO cleared.
  - mem_addr loaded with base_addr.
  - Concurrent handshake discarded, with no err.
  - in_ready stays as computed before the edge.

Reset
REQ-028 Asynchronous rst forces: FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, err=0, in_ready=1.
REQ-029 rst asserted mid-operation discards all buffered words; no partial write completes after rst rises.

Configuration
REQ-030 Macro INSTR_COUNT_EN, when defined, adds output word_count (16 bits):
  - Counts completed pops.
  - Cleared by rst and restart.
  - Saturates at 0xFFFF.
REQ-031 Without INSTR_COUNT_EN, the port and counter are absent; all other behaviour is identical.

Verification
REQ-032 Reset then restart with base_addr=0x100; push add rd=1 rs1=2 rs2=3 (R-type) with mem_ready=1 -> one write, mem_addr=0x100, mem_wdata=0x003100B3.
REQ-033 Push sub rd=5 rs1=6 rs2=7, then I-type sra rd=1 rs1=1 imm=0x003 -> words 0x407302B3 then 0x4030D093, at addresses base and base+4.
REQ-034 mem_ready=0 with 5 back-to-back legal pushes (FIFO_DEPTH=4) -> in_ready low after the 4th acceptance; release mem_ready -> 4 words in order, then the 5th accepted.
REQ-035 Push op=1 with imm_sel=1, then op=12 -> err pulses twice, no mem_we, FIFO stays empty.
REQ-036 Assert rst with 3 words buffered and mem_ready=0 -> outputs match REQ-028 immediately; no write follows.
REQ-037 With INSTR_COUNT_EN defined, 3 pops then restart -> word_count reads 3, then 0.
